// File: rtl/axis_traffic_gen.sv
// axis_traffic_gen: AXI-Stream packet traffic generator.
// A run sends cfg_trans_len bytes split into packets of up to cfg_pkt_len
// bytes. Packets rotate round-robin over CH_NUM channels and are separated by
// cfg_pkt_gap idle cycles. Data is a word increment, a fixed word or a byte
// ramp, and the sequence continues across packet boundaries.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   cfg_*                run configuration, latched on an accepted start
//   stream_start         start pulse (only in IDLE, both lengths non-zero)
//   stream_stop          stop request: finish the current packet, then idle
//   stream_busy          high from the accepted start to the end of the run
//   pkt_cnt, byte_cnt    packets / tkeep-counted bytes accepted this run
//   m_axis_*             AXI-Stream master
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high. While tvalid is high and tready low, every payload field stays
// unchanged, and tvalid never drops without a transfer (except on reset).
module axis_traffic_gen #(
  parameter int TBYTE_NUM  = 1,
  parameter int DEST_WIDTH = 5,
  parameter int CH_NUM     = 4,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [DEST_WIDTH-1:0]  cfg_dest_base,
  input  logic [31:0]            cfg_pkt_gap,
  input  logic [LEN_WIDTH-1:0]   cfg_pkt_len,
  input  logic [LEN_WIDTH-1:0]   cfg_trans_len,
  input  logic [8*TBYTE_NUM-1:0] cfg_start_from,
  input  logic [8*TBYTE_NUM-1:0] cfg_inc,
  input  logic [1:0]             cfg_mode,
  input  logic                   stream_start,
  input  logic                   stream_stop,
  output logic                   stream_busy,
  output logic [LEN_WIDTH-1:0]   pkt_cnt,
  output logic [LEN_WIDTH-1:0]   byte_cnt,
  output logic [8*TBYTE_NUM-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [TBYTE_NUM-1:0]   m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic [DEST_WIDTH-1:0]  m_axis_tid,
  output logic [DEST_WIDTH-1:0]  m_axis_tdest
);
  localparam int DW = 8 * TBYTE_NUM;
  localparam logic [LEN_WIDTH-1:0] BEAT_BYTES = LEN_WIDTH'(TBYTE_NUM);
  // In byte-ramp mode every lane advances by TBYTE_NUM steps per beat.
  localparam logic [7:0] LANE_STEP = 8'(TBYTE_NUM);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_e;

  state_e                state_q, state_d;
  logic                  stop_q, stop_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;          // run bytes not yet accepted
  logic [LEN_WIDTH-1:0]  pkt_rem_q, pkt_rem_d;  // packet bytes not yet accepted
  logic [LEN_WIDTH-1:0]  pkt_len_q, pkt_len_d;
  logic [LEN_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [LEN_WIDTH-1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0]           gap_q, gap_d;
  logic [31:0]           gap_cnt_q, gap_cnt_d;
  logic [DW-1:0]         data_q, data_d;
  logic [DW-1:0]         inc_q, inc_d;
  logic [1:0]            mode_q, mode_d;
  logic [DEST_WIDTH-1:0] base_q, base_d;
  logic [DEST_WIDTH-1:0] chan_q, chan_d;

  logic                  last_beat;
  logic [LEN_WIDTH-1:0]  beat_bytes;
  logic [LEN_WIDTH-1:0]  rem_after;

  function automatic logic [LEN_WIDTH-1:0] min_len(input logic [LEN_WIDTH-1:0] a,
                                                   input logic [LEN_WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DW-1:0] ramp_init(input logic [7:0] seed, input logic [7:0] step);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < TBYTE_NUM; i++) r[8*i +: 8] = seed + 8'(i) * step;
    return r;
  endfunction

  function automatic logic [DW-1:0] next_data(input logic [DW-1:0] cur,
                                              input logic [DW-1:0] inc,
                                              input logic [1:0]    mode);
    logic [DW-1:0] r;
    r = cur;
    case (mode)
      2'd1:    r = cur;
      2'd2:    for (int i = 0; i < TBYTE_NUM; i++) r[8*i +: 8] = cur[8*i +: 8] + LANE_STEP * inc[7:0];
      default: r = cur + inc;  // modes 0 and 3
    endcase
    return r;
  endfunction

  // The packet's last beat carries whatever is left of the packet.
  assign last_beat  = (pkt_rem_q <= BEAT_BYTES);
  assign beat_bytes = last_beat ? pkt_rem_q : BEAT_BYTES;
  assign rem_after  = rem_q - beat_bytes;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      stop_q     <= 1'b0;
      rem_q      <= '0;
      pkt_rem_q  <= '0;
      pkt_len_q  <= '0;
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      data_q     <= '0;
      inc_q      <= '0;
      mode_q     <= '0;
      base_q     <= '0;
      chan_q     <= '0;
    end else begin
      state_q    <= state_d;
      stop_q     <= stop_d;
      rem_q      <= rem_d;
      pkt_rem_q  <= pkt_rem_d;
      pkt_len_q  <= pkt_len_d;
      pkt_cnt_q  <= pkt_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      gap_q      <= gap_d;
      gap_cnt_q  <= gap_cnt_d;
      data_q     <= data_d;
      inc_q      <= inc_d;
      mode_q     <= mode_d;
      base_q     <= base_d;
      chan_q     <= chan_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stop_d     = stop_q;
    rem_d      = rem_q;
    pkt_rem_d  = pkt_rem_q;
    pkt_len_d  = pkt_len_q;
    pkt_cnt_d  = pkt_cnt_q;
    byte_cnt_d = byte_cnt_q;
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
    data_d     = data_q;
    inc_d      = inc_q;
    mode_d     = mode_q;
    base_d     = base_q;
    chan_d     = chan_q;
    case (state_q)
      IDLE: begin
        // stream_stop is ignored here, so a simultaneous start wins.
        if (stream_start && (cfg_pkt_len != '0) && (cfg_trans_len != '0)) begin
          state_d    = SEND;
          stop_d     = 1'b0;
          pkt_cnt_d  = '0;
          byte_cnt_d = '0;
          chan_d     = '0;
          pkt_len_d  = cfg_pkt_len;
          gap_d      = cfg_pkt_gap;
          inc_d      = cfg_inc;
          mode_d     = cfg_mode;
          base_d     = cfg_dest_base;
          rem_d      = cfg_trans_len;
          pkt_rem_d  = min_len(cfg_pkt_len, cfg_trans_len);
          data_d     = (cfg_mode == 2'd2) ? ramp_init(cfg_start_from[7:0], cfg_inc[7:0])
                                          : cfg_start_from;
        end
      end
      SEND: begin
        if (stream_stop) stop_d = 1'b1;
        if (m_axis_tready) begin
          byte_cnt_d = byte_cnt_q + beat_bytes;
          rem_d      = rem_after;
          pkt_rem_d  = pkt_rem_q - beat_bytes;
          data_d     = next_data(data_q, inc_q, mode_q);
          if (last_beat) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
            chan_d    = (32'(chan_q) == CH_NUM - 1) ? '0 : chan_q + 1'b1;
            pkt_rem_d = min_len(pkt_len_q, rem_after);
            // A stop arriving on the tlast edge itself also ends the run.
            if ((rem_after == '0) || stop_q || stream_stop) begin
              state_d = IDLE;
            end else if (gap_q != 32'd0) begin
              state_d   = GAP;
              gap_cnt_d = gap_q;
            end
          end
        end
      end
      GAP: begin
        if (stop_q || stream_stop) begin
          stop_d  = 1'b1;
          state_d = IDLE;
        end else if (gap_cnt_q == 32'd1) begin
          state_d = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tvalid/busy decode straight from the state register, so the async
  // reset removes them immediately.
  assign m_axis_tvalid = (state_q == SEND);
  assign stream_busy   = (state_q != IDLE);
  assign m_axis_tlast  = m_axis_tvalid && last_beat;
  assign m_axis_tdata  = data_q;
  assign m_axis_tid    = chan_q;
  assign m_axis_tdest  = base_q + chan_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign byte_cnt      = byte_cnt_q;

  // Lane i is enabled while more than i packet bytes remain: contiguous
  // from lane 0, all ones on every beat except a short last beat.
  always_comb begin
    m_axis_tkeep = '0;
    for (int i = 0; i < TBYTE_NUM; i++) m_axis_tkeep[i] = m_axis_tvalid && (pkt_rem_q > LEN_WIDTH'(i));
  end
endmodule
